// File: rtl/parity_serial_rx.sv
// Serial receiver for the XOR-parity link: deframes start / DATA_W data (LSB first) /
// parity / stop from an asynchronous idle-high line and flags parity and framing errors.
module parity_serial_rx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rxd,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W  = $clog2(DATA_W + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_W - 1);
  localparam logic              PAR_INIT  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
  } state_t;

  // Handshake: valid is a one-cycle pulse with no backpressure; data_out, parity_err
  // and frame_err describe the word only in the cycle valid is high.

  logic              sync1, rxs;
  state_t            state, state_n;
  logic [TICK_W-1:0] tick, tick_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [DATA_W-1:0] shift, shift_n;
  logic              par, par_n;
  logic              perr, perr_n;
  logic [DATA_W-1:0] data_n;
  logic              valid_n, parity_err_n, frame_err_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= 1'b1;
      rxs        <= 1'b1;
      state      <= S_IDLE;
      tick       <= '0;
      idx        <= '0;
      shift      <= '0;
      par        <= 1'b0;
      perr       <= 1'b0;
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync1      <= rxd;
      rxs        <= sync1;
      state      <= state_n;
      tick       <= tick_n;
      idx        <= idx_n;
      shift      <= shift_n;
      par        <= par_n;
      perr       <= perr_n;
      data_out   <= data_n;
      valid      <= valid_n;
      parity_err <= parity_err_n;
      frame_err  <= frame_err_n;
    end
  end

  always_comb begin
    state_n      = state;
    tick_n       = tick;
    idx_n        = idx;
    shift_n      = shift;
    par_n        = par;
    perr_n       = perr;
    data_n       = data_out;
    valid_n      = 1'b0;
    parity_err_n = 1'b0;
    frame_err_n  = 1'b0;

    case (state)
      S_IDLE: begin
        tick_n = '0;
        if (!rxs) state_n = S_START;
      end
      // A low that has gone high again by mid start bit is treated as a glitch.
      S_START: begin
        if (tick == HALF_LAST) begin
          tick_n = '0;
          if (!rxs) begin
            state_n = S_DATA;
            idx_n   = '0;
            par_n   = PAR_INIT;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          tick_n = tick + 1'b1;
        end
      end
      S_DATA: begin
        if (tick == TICK_LAST) begin
          tick_n              = '0;
          shift_n             = shift >> 1;
          shift_n[DATA_W-1]   = rxs;
          par_n               = par ^ rxs;
          idx_n               = idx + 1'b1;
          if (idx == IDX_LAST) state_n = S_PARITY;
        end else begin
          tick_n = tick + 1'b1;
        end
      end
      S_PARITY: begin
        if (tick == TICK_LAST) begin
          tick_n  = '0;
          perr_n  = par ^ rxs;
          state_n = S_STOP;
        end else begin
          tick_n = tick + 1'b1;
        end
      end
      // The word is presented in the DONE cycle so busy still covers the valid pulse.
      S_STOP: begin
        if (tick == TICK_LAST) begin
          tick_n       = '0;
          valid_n      = 1'b1;
          data_n       = shift;
          parity_err_n = perr;
          frame_err_n  = ~rxs;
          state_n      = S_DONE;
        end else begin
          tick_n = tick + 1'b1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
        tick_n  = '0;
      end
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_parity_serial_rx.sv
// Bench for parity_serial_rx: an even-parity and an odd-parity receiver share one line;
// each sent frame pushes its expected word/flags/arrival cycle, monitors pop on valid.
module tb_parity_serial_rx;

  localparam int DW  = 8;
  localparam int CPB = 16;
  localparam int LAT = 2 + CPB / 2 + (DW + 2) * CPB;

  typedef struct packed {
    logic [31:0]   cyc;
    logic          ferr;
    logic          perr;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rxd = 1'b1;
  logic [DW-1:0] data_e, data_o;
  logic          valid_e, valid_o, perr_e, perr_o, ferr_e, ferr_o, busy_e, busy_o;

  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;
  exp_t        exp_e[$];
  exp_t        exp_o[$];
  exp_t        got_e, got_o;

  parity_serial_rx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut_even (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .data_out(data_e), .valid(valid_e),
    .parity_err(perr_e), .frame_err(ferr_e), .busy(busy_e)
  );

  parity_serial_rx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_ODD(1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .data_out(data_o), .valid(valid_o),
    .parity_err(perr_o), .frame_err(ferr_o), .busy(busy_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic compare_word(input string tag, input exp_t e, input logic [DW-1:0] d,
                              input logic p, input logic f);
    check({tag, "_data"}, 32'(d), 32'(e.data));
    check({tag, "_parity_err"}, 32'(p), 32'(e.perr));
    check({tag, "_frame_err"}, 32'(f), 32'(e.ferr));
    check({tag, "_latency_cycle"}, cyc, e.cyc);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_e) begin
        if (exp_e.size() == 0) check("even_unexpected_valid", 32'd1, 32'd0);
        else begin
          got_e = exp_e.pop_front();
          compare_word("even", got_e, data_e, perr_e, ferr_e);
        end
      end else begin
        check("even_flags_without_valid", {30'd0, perr_e, ferr_e}, 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_o) begin
        if (exp_o.size() == 0) check("odd_unexpected_valid", 32'd1, 32'd0);
        else begin
          got_o = exp_o.pop_front();
          compare_word("odd", got_o, data_o, perr_o, ferr_o);
        end
      end else begin
        check("odd_flags_without_valid", {30'd0, perr_o, ferr_o}, 32'd0);
      end
    end
  end

  // ---------------- reference model + drivers ----------------
  function automatic logic even_par_of(input logic [DW-1:0] d);
    return logic'($countones(d) % 2);
  endfunction

  task automatic expect_frame(input logic [DW-1:0] d, input logic p, input logic s);
    exp_t e;
    int   ones;
    ones   = $countones(d) + int'(p);
    e.data = d;
    e.ferr = !s;
    e.cyc  = cyc + 1 + LAT;
    e.perr = (ones % 2) != 0;
    exp_e.push_back(e);
    e.perr = (ones % 2) == 0;
    exp_o.push_back(e);
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic s);
    expect_frame(d, p, s);
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(s);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_even_outputs"}, {data_e, valid_e, perr_e, ferr_e, busy_e}, 32'd0);
    check({tag, "_odd_outputs"}, {data_o, valid_o, perr_o, ferr_o, busy_o}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] d;
    logic          p, s;
    int            wait_cnt;

    rst_n = 1'b0;
    rxd   = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rxd = ~rxd;
      if (i == 5) check_quiet("in_reset");
    end
    check_quiet("in_reset_end");
    rxd   = 1'b1;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_quiet("after_release");

    send_frame(8'hA5, 1'b0, 1'b1);
    idle(2 * CPB);
    send_frame(8'h01, 1'b0, 1'b1);
    idle(CPB);
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(CPB);
    send_frame(8'h5A, 1'b0, 1'b1);
    idle(2 * CPB);

    // short low pulse on the idle line
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    check("glitch_busy_high", 32'(busy_e), 32'd1);
    repeat (2 * CPB) @(negedge clk);
    check("glitch_busy_even_cleared", 32'(busy_e), 32'd0);
    check("glitch_busy_odd_cleared", 32'(busy_o), 32'd0);

    // reset in the middle of data bit 3; the frame must be dropped
    d = 8'h96;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    rxd = d[3];
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (2) @(negedge clk);
    check_quiet("mid_frame_reset");
    rst_n = 1'b1;
    idle(3 * CPB);
    check("abort_busy_even", 32'(busy_e), 32'd0);
    send_frame(8'hFF, 1'b0, 1'b1);
    idle(CPB);

    // back-to-back frames with no idle between stop and start
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    send_frame(8'h81, 1'b0, 1'b1);
    idle(CPB);

    for (int n = 0; n < 14; n++) begin
      d = DW'($urandom_range(0, 255));
      p = even_par_of(d) ^ ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 7) != 0);
      send_frame(d, p, s);
      if (s) idle(int'($urandom_range(0, 20)));
      else idle(CPB + int'($urandom_range(0, 20)));
    end

    wait_cnt = 0;
    while ((exp_e.size() != 0 || exp_o.size() != 0) && wait_cnt < 4 * LAT) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("even_queue_drained", 32'(exp_e.size()), 32'd0);
    check("odd_queue_drained", 32'(exp_o.size()), 32'd0);
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog_timeout actual=%0d required=finished (cycle count)", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
